// File: rtl/alu_pkg.sv
// Shared opcode map, FSM encoding and opcode classifiers for the ALU issue controller.
package alu_pkg;

    localparam logic [7:0] OP_ADD    = 8'h71;
    localparam logic [7:0] OP_AND    = 8'h72;
    localparam logic [7:0] OP_CLA    = 8'h73;
    localparam logic [7:0] OP_CLB    = 8'h74;
    localparam logic [7:0] OP_CMA    = 8'h75;
    localparam logic [7:0] OP_INC    = 8'h76;
    localparam logic [7:0] OP_DEC    = 8'h77;
    localparam logic [7:0] OP_BIT_LO = 8'h78;
    localparam logic [7:0] OP_BIT_HI = 8'h7D;

    // Not decoded by the ALU, so its output registers hold.
    localparam logic [7:0] IDLE_OP = 8'h00;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StCapt,
        StResp
    } alu_state_e;

    function automatic logic is_legal_op(input logic [7:0] op);
        return (op >= OP_ADD) && (op <= OP_BIT_HI);
    endfunction

    function automatic logic sets_flags(input logic [7:0] op);
        return (op >= OP_ADD) && (op <= OP_DEC);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Requester/response bundle between issue logic (master) and the ALU issue controller (slave).
interface alu_issue_ctrl_if #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned DW   = 16,
    parameter int unsigned OPW  = 8
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*OPW-1:0] req_opcode;
    logic [NREQ*DW-1:0]  req_a;
    logic [NREQ*DW-1:0]  req_b;
    logic                rsp_valid;
    logic [IW-1:0]       rsp_id;
    logic [NREQ-1:0]     rsp_ready;
    logic [DW-1:0]       rsp_result;
    logic                rsp_carry;
    logic                rsp_zero;
    logic                rsp_flags_vld;
    logic                rsp_err;

    modport master (
        output req_valid, req_opcode, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero,
               rsp_flags_vld, rsp_err
    );

    modport slave (
        input  req_valid, req_opcode, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero,
               rsp_flags_vld, rsp_err
    );

endinterface

// File: rtl/alu_issue_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer, pointer moves past the winner on en.
module rr_arbiter #(
    parameter int unsigned NREQ = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic                  en,
    output logic [NREQ-1:0]       grant,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] grant_idx
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0] ptr_q, ptr_d;

    always_comb begin
        int unsigned idx;
        logic        found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(ptr_q) + i) % NREQ;
            if (!found && req[idx]) begin
                found     = 1'b1;
                grant[idx] = 1'b1;
                grant_idx = IW'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (en) begin
            ptr_d = IW'((32'(grant_idx) + 1) % NREQ);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Arbitrates requesters onto one registered ALU: grant, issue, capture one cycle later, respond.
module alu_issue_ctrl #(
    parameter int unsigned     NREQ    = 2,
    parameter int unsigned     DW      = 16,
    parameter int unsigned     OPW     = 8,
    parameter logic [OPW-1:0]  IDLE_OP = alu_pkg::IDLE_OP
) (
    input  logic                clk,
    input  logic                rst,
    alu_issue_ctrl_if.slave     bus,
    output logic [OPW-1:0]      alu_opcode,
    output logic [DW-1:0]       alu_read_a,
    output logic [DW-1:0]       alu_read_b,
    input  logic [DW-1:0]       alu_result,
    input  logic                alu_carry,
    input  logic                alu_zero,
    output logic                busy,
    output logic [15:0]         op_count
);
    import alu_pkg::*;

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    alu_state_e state_q, state_d;

    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grant_idx;
    logic            any_req;
    logic            take;
    logic [OPW-1:0]  sel_op;
    logic [DW-1:0]   sel_a, sel_b;
    logic            sel_legal;
    logic            resp_ack;

    logic [OPW-1:0]  op_q, op_d;
    logic [OPW-1:0]  alu_opcode_q, alu_opcode_d;
    logic [DW-1:0]   alu_read_a_q, alu_read_a_d;
    logic [DW-1:0]   alu_read_b_q, alu_read_b_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IW-1:0]   rsp_id_q, rsp_id_d;
    logic [DW-1:0]   rsp_result_q, rsp_result_d;
    logic            rsp_carry_q, rsp_carry_d;
    logic            rsp_zero_q, rsp_zero_d;
    logic            rsp_flags_vld_q, rsp_flags_vld_d;
    logic            rsp_err_q, rsp_err_d;
    logic [15:0]     op_count_q, op_count_d;

    assign any_req   = |bus.req_valid;
    assign take      = (state_q == StIdle) && any_req;
    assign sel_op    = bus.req_opcode[grant_idx*OPW +: OPW];
    assign sel_a     = bus.req_a[grant_idx*DW +: DW];
    assign sel_b     = bus.req_b[grant_idx*DW +: DW];
    assign sel_legal = is_legal_op(sel_op);
    assign resp_ack  = bus.rsp_ready[rsp_id_q];

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.req_valid),
        .en        (take),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (any_req) state_d = sel_legal ? StIssue : StResp;
            StIssue: state_d = StCapt;
            StCapt:  state_d = StResp;
            StResp:  if (resp_ack) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        op_d            = op_q;
        alu_opcode_d    = alu_opcode_q;
        alu_read_a_d    = alu_read_a_q;
        alu_read_b_d    = alu_read_b_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_id_d        = rsp_id_q;
        rsp_result_d    = rsp_result_q;
        rsp_carry_d     = rsp_carry_q;
        rsp_zero_d      = rsp_zero_q;
        rsp_flags_vld_d = rsp_flags_vld_q;
        rsp_err_d       = rsp_err_q;
        op_count_d      = op_count_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    rsp_id_d = grant_idx;
                    op_d     = sel_op;
                    if (sel_legal) begin
                        alu_opcode_d = sel_op;
                        alu_read_a_d = sel_a;
                        alu_read_b_d = sel_b;
                    end else begin
                        // Illegal ops never reach the ALU; answer straight away.
                        rsp_valid_d     = 1'b1;
                        rsp_err_d       = 1'b1;
                        rsp_result_d    = '0;
                        rsp_carry_d     = 1'b0;
                        rsp_zero_d      = 1'b0;
                        rsp_flags_vld_d = 1'b0;
                    end
                end
            end
            StIssue: begin
                op_count_d   = op_count_q + 16'd1;
                alu_opcode_d = IDLE_OP;
            end
            StCapt: begin
                rsp_valid_d     = 1'b1;
                rsp_err_d       = 1'b0;
                rsp_result_d    = alu_result;
                rsp_carry_d     = alu_carry;
                rsp_zero_d      = alu_zero;
                rsp_flags_vld_d = sets_flags(op_q);
            end
            StResp: begin
                if (resp_ack) rsp_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q            <= IDLE_OP;
            alu_opcode_q    <= IDLE_OP;
            alu_read_a_q    <= '0;
            alu_read_b_q    <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_id_q        <= '0;
            rsp_result_q    <= '0;
            rsp_carry_q     <= 1'b0;
            rsp_zero_q      <= 1'b0;
            rsp_flags_vld_q <= 1'b0;
            rsp_err_q       <= 1'b0;
            op_count_q      <= '0;
        end else begin
            op_q            <= op_d;
            alu_opcode_q    <= alu_opcode_d;
            alu_read_a_q    <= alu_read_a_d;
            alu_read_b_q    <= alu_read_b_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_id_q        <= rsp_id_d;
            rsp_result_q    <= rsp_result_d;
            rsp_carry_q     <= rsp_carry_d;
            rsp_zero_q      <= rsp_zero_d;
            rsp_flags_vld_q <= rsp_flags_vld_d;
            rsp_err_q       <= rsp_err_d;
            op_count_q      <= op_count_d;
        end
    end

    // Accept pulse is combinational so the handshake completes on the granting edge.
    assign bus.req_ready     = (take && !rst) ? grant : '0;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_id        = rsp_id_q;
    assign bus.rsp_result    = rsp_result_q;
    assign bus.rsp_carry     = rsp_carry_q;
    assign bus.rsp_zero      = rsp_zero_q;
    assign bus.rsp_flags_vld = rsp_flags_vld_q;
    assign bus.rsp_err       = rsp_err_q;

    assign alu_opcode = alu_opcode_q;
    assign alu_read_a = alu_read_a_q;
    assign alu_read_b = alu_read_b_q;
    assign busy       = (state_q != StIdle);
    assign op_count   = op_count_q;

endmodule
